mod_shift_iter: RTL
===================

MOD_SHIFT_ITER -- requirements
Module: mod_shift_iter

Interface
REQ-001 Parameter BITWIDTH, default 8, width of data, modulus and result.
REQ-002 Parameter SHIFTW, default 4, width of step-count input; max steps 2^SHIFTW-1.
REQ-003 iClk  input  1  sole clock, all state updates on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iClr  input  1  synchronous abort/clear.
REQ-006 iValid  input  1  request valid.
REQ-007 oReady  output  1  block can accept a request.
REQ-008 iData  input  BITWIDTH  operand x, expected x < Q.
REQ-009 iQ  input  BITWIDTH  modulus Q, expected Q >= 2; odd for halve mode.
REQ-010 iShamt  input  SHIFTW  step count k.
REQ-011 iMode  input  1  0 = modular doubling, 1 = modular halving.
REQ-012 oValid  output  1  result valid.
REQ-013 iReady  input  1  downstream accepts result.
REQ-014 oData  output  BITWIDTH  result: x*2^k mod Q (mode 0) or x*2^-k mod Q (mode 1).

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE; oReady SHALL equal (state==IDLE), combinational from state only.
REQ-016 Accept SHALL occur on an edge with iValid & oReady; the block SHALL latch iData into the working register, and iQ, iMode, iShamt internally; inputs SHALL be ignored outside IDLE.
REQ-017 On accept with k=0 the block SHALL go IDLE->DONE with oData = iData unchanged.
REQ-018 On accept with k>0 the block SHALL go IDLE->RUN with step counter = k.
REQ-019 In RUN each edge SHALL perform exactly one step on the working value and decrement the counter; the edge where counter==1 SHALL transition to DONE.
REQ-020 Doubling step SHALL form s={x,1'b0} at BITWIDTH+1 bits and produce s<Q ? s : s-Q, compared at BITWIDTH+1 bits.
REQ-021 Halving step SHALL produce x>>1 if x even, else (x+Q)>>1 with x+Q formed at BITWIDTH+1 bits (carry retained).
REQ-022 Latency: oValid SHALL be high in the cycle after edge T+k, where T is the accept edge (k+1 cycles).
REQ-023 In DONE, oValid=1 and oData SHALL hold stable until an edge with iReady=1, which SHALL return to IDLE and drop oValid; no new accept in that same edge.
REQ-024 oData SHALL hold the last result in IDLE; it updates only on accept and RUN steps.
REQ-025 iClr on any edge SHALL force IDLE, oData=0, oValid=0, discarding any in-flight operation; iClr SHALL override accept and iReady in that edge.
REQ-026 Out-of-contract inputs (x>=Q, even Q in mode 1) SHALL still follow REQ-020/021 deterministically; no error output.
REQ-027 Max throughput SHALL be one result per k+2 cycles.

Reset
REQ-028 iRst SHALL have priority over iClr and all other inputs.
REQ-029 On iRst the block SHALL set state IDLE, oData=0, oValid=0, counter=0; oReady=1 in the cycle after reset.
REQ-030 iRst asserted in RUN or DONE SHALL abort the operation with no oValid pulse.

Verification
REQ-031 BITWIDTH=8, Q=97, mode 0, x=60, k=3 -> steps 23, 46, 92; oData=92, oValid 4 cycles after accept.
REQ-032 Q=97, mode 1, x=5, k=2 -> 51 then 74; oData=74; k=0, x=42 -> oData=42 one cycle after accept.
REQ-033 Carry: Q=251, mode 0, x=250, k=1 -> 249; mode 1, x=249, k=1 -> 250.
REQ-034 Backpressure: hold iReady=0 for 5 cycles in DONE with iValid=1 and new operands -> oData, oValid stable, oReady=0, no accept; iReady=1 -> IDLE next cycle.
REQ-035 iClr asserted at second RUN step of k=5 -> IDLE, oData=0, no oValid; iRst in DONE -> oValid=0, oData=0 next cycle.

Source files
------------

// File: rtl/mod_shift_iter.sv
// Iterative modular doubling/halving: one step per cycle, result = x*2^(+/-k) mod Q.
// Latency k+1 cycles from accept to oValid; result held in DONE until iReady.
module mod_shift_iter #(
    parameter int BITWIDTH = 8,
    parameter int SHIFTW   = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    input  logic [SHIFTW-1:0]   iShamt,
    input  logic                iMode,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SHIFTW-1:0]   cnt_q, cnt_d;
    logic [BITWIDTH-1:0] x_q, x_d;
    logic [BITWIDTH-1:0] q_q, q_d;
    logic                mode_q, mode_d;

    // Both step variants work at BITWIDTH+1 bits so the doubling overflow
    // and the halving carry are never lost, even for out-of-range operands.
    logic [BITWIDTH:0]   q_ext;
    logic [BITWIDTH:0]   dbl;
    logic [BITWIDTH:0]   dbl_red;
    logic [BITWIDTH:0]   hsum;
    logic [BITWIDTH-1:0] step_val;

    always_comb begin
        q_ext   = {1'b0, q_q};
        dbl     = {x_q, 1'b0};
        dbl_red = (dbl < q_ext) ? dbl : (dbl - q_ext);
        hsum    = {1'b0, x_q} + (x_q[0] ? q_ext : '0);
        if (mode_q) begin
            step_val = hsum[BITWIDTH:1];
        end else begin
            step_val = dbl_red[BITWIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        q_d     = q_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    x_d     = iData;
                    q_d     = iQ;
                    mode_d  = iMode;
                    cnt_d   = iShamt;
                    state_d = (iShamt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                x_d   = step_val;
                cnt_d = cnt_q - SHIFTW'(1);
                if (cnt_q == SHIFTW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (iReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Clear wins over accept and handshake in the same edge.
        if (iClr) begin
            state_d = IDLE;
            x_d     = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            q_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
        end
    end

    assign oReady = (state_q == IDLE);
    assign oValid = (state_q == DONE);
    assign oData  = x_q;

endmodule
